// File: rtl/dbgbus_pkg.sv
// Shared encodings for the 34-bit debug-bus command/response interface.
// Used by the initiator, the bus master and the testbench model.
package dbgbus_pkg;

  // cmd_word[33:32]
  localparam logic [1:0] CMD_SETADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_READ    = 2'b10;

  // rsp_word[33:32]
  localparam logic [1:0] RSP_ADDR  = 2'b00;
  localparam logic [1:0] RSP_WACK  = 2'b01;
  localparam logic [1:0] RSP_RDATA = 2'b10;
  localparam logic [1:0] RSP_ERR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_ADDR = 3'd1,
    ST_SEND_OP   = 3'd2,
    ST_WAIT_RSP  = 3'd3,
    ST_RESP      = 3'd4
  } dbgbus_state_t;

  function automatic logic [33:0] mk_cmd(input logic [1:0] op, input logic [31:0] payload);
    return {op, payload};
  endfunction

  // Address the master will hold after one auto-increment; wraps modulo 2^32.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/dbgbus_timeout.sv
// Response timeout for the debug-bus initiator.
// Down-counter loaded on clr; expired pulses on the TIMEOUT_CYCLES-th enabled cycle
// after the load (terminal count of zero while enabled).
module dbgbus_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Load on clear, count down while waiting, park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= LOAD_VAL;
    end else if (clr) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Terminal-count compare.
  always_comb begin
    expired = en && (cnt_q == '0);
  end

endmodule

// File: rtl/dbgbus_initiator.sv
// Host-side debug-bus initiator: turns single-word load/store requests into
// set-address + read/write command sequences and returns the matching response.
// Keeps a copy of the master's auto-incremented address so that sequential
// accesses skip the set-address command.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | req_ready high, waiting for a request
// ST_SEND_ADDR | presenting {00,addr}, held while cmd_busy
// ST_SEND_OP   | presenting the write or read command, held while cmd_busy
// ST_WAIT_RSP  | waiting for write ack / read data / bus error, timeout armed
// ST_RESP      | one-cycle resp_valid pulse back to the CPU
module dbgbus_initiator
  import dbgbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit ADDR_CACHE     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        cmd_stb,
  output logic [33:0] cmd_word,
  input  logic        cmd_busy,
  input  logic        rsp_stb,
  input  logic [33:0] rsp_word
);

  dbgbus_state_t state_q, state_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        cache_valid_q;
  logic [31:0] cache_addr_q;

  logic        req_take;
  logic        req_misaligned;
  logic        cache_hit;
  logic        cmd_xfer;
  logic [1:0]  rsp_type;
  logic        rsp_ok;
  logic        rsp_bad;
  logic        to_clr;
  logic        to_en;
  logic        to_expired;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cmd_stb_d;
  logic [33:0] cmd_word_d;

  assign req_take       = (state_q == ST_IDLE) && req_valid;
  assign req_misaligned = (req_addr[1:0] != 2'b00);
  assign cache_hit      = ADDR_CACHE && cache_valid_q && (req_addr == cache_addr_q);
  assign cmd_xfer       = cmd_stb && !cmd_busy;
  assign rsp_type       = rsp_word[33:32];
  // Address echoes are dropped; only ack, data or error end the wait.
  assign rsp_ok  = (state_q == ST_WAIT_RSP) && rsp_stb &&
                   ((rsp_type == RSP_WACK) || (rsp_type == RSP_RDATA));
  assign rsp_bad = (state_q == ST_WAIT_RSP) && rsp_stb && (rsp_type == RSP_ERR);

  // Counter restarts as the op command leaves; it only runs in WAIT_RSP, so a
  // master that never drops cmd_busy stalls rather than times out.
  assign to_clr = (state_q == ST_SEND_OP) && cmd_xfer;
  assign to_en  = (state_q == ST_WAIT_RSP);

  dbgbus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (to_clr),
    .en     (to_en),
    .expired(to_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_misaligned) begin
            state_d = ST_RESP;
          end else if (cache_hit) begin
            state_d = ST_SEND_OP;
          end else begin
            state_d = ST_SEND_ADDR;
          end
        end
      end
      ST_SEND_ADDR: begin
        if (cmd_xfer) state_d = ST_SEND_OP;
      end
      ST_SEND_OP: begin
        if (cmd_xfer) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (rsp_ok || rsp_bad || to_expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: ready flag and the command the next state will present.
  // In IDLE the request fields come straight from the port so the first
  // command is registered on the handshake edge.
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    cur_we     = (state_q == ST_IDLE) ? req_we    : we_q;
    cur_addr   = (state_q == ST_IDLE) ? req_addr  : addr_q;
    cur_wdata  = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    cmd_stb_d  = 1'b0;
    cmd_word_d = cmd_word;
    case (state_d)
      ST_SEND_ADDR: begin
        cmd_stb_d  = 1'b1;
        cmd_word_d = mk_cmd(CMD_SETADDR, cur_addr);
      end
      ST_SEND_OP: begin
        cmd_stb_d  = 1'b1;
        cmd_word_d = cur_we ? mk_cmd(CMD_WRITE, cur_wdata) : mk_cmd(CMD_READ, 32'h0);
      end
      default: begin
        cmd_stb_d  = 1'b0;
      end
    endcase
  end

  // Command port registers; stable under cmd_busy because the state holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_stb  <= 1'b0;
      cmd_word <= '0;
    end else begin
      cmd_stb  <= cmd_stb_d;
      cmd_word <= cmd_word_d;
    end
  end

  // Capture the request on the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (req_take) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // CPU response registers; rdata and err hold between completions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= (state_d == ST_RESP);
      if (req_take && req_misaligned) begin
        resp_err <= 1'b1;
      end else if (rsp_ok) begin
        resp_err <= 1'b0;
        if (!we_q) resp_rdata <= rsp_word[31:0];
      end else if (rsp_bad || to_expired) begin
        resp_err <= 1'b1;
      end
    end
  end

  // Shadow of the master's address pointer; any failure leaves it unknown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
    end else if (rsp_ok) begin
      cache_valid_q <= 1'b1;
      cache_addr_q  <= next_word_addr(addr_q);
    end else if (rsp_bad || to_expired) begin
      cache_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dbgbus_initiator.sv
module tb_dbgbus_initiator;
  import dbgbus_pkg::*;

  localparam int TO_CYC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        cmd_busy;
  logic        rsp_stb;
  logic [33:0] rsp_word;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic [33:0] exp_cmd_q[$];
  resp_t       exp_resp_q[$];

  int total = 0;
  int bad   = 0;

  dbgbus_initiator #(
    .TIMEOUT_CYCLES(TO_CYC),
    .ADDR_CACHE    (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .cmd_stb   (cmd_stb),
    .cmd_word  (cmd_word),
    .cmd_busy  (cmd_busy),
    .rsp_stb   (rsp_stb),
    .rsp_word  (rsp_word)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every transferred command and every completion is popped here.
  always @(negedge clk) begin
    logic [33:0] ec;
    resp_t       er;
    if (!reset) begin
      if (cmd_stb && !cmd_busy) begin
        total++;
        if (exp_cmd_q.size() == 0) begin
          bad++;
          $display("FAIL cmd_unexpected: got %h, none expected", cmd_word);
        end else begin
          ec = exp_cmd_q.pop_front();
          if (cmd_word !== ec) begin
            bad++;
            $display("FAIL cmd_word: got %h want %h", cmd_word, ec);
          end
        end
      end
      if (resp_valid) begin
        total++;
        if (exp_resp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: got rdata=%h err=%b, none expected", resp_rdata, resp_err);
        end else begin
          er = exp_resp_q.pop_front();
          if ((resp_rdata !== er.rdata) || (resp_err !== er.err)) begin
            bad++;
            $display("FAIL resp: got rdata=%h err=%b want rdata=%h err=%b",
                     resp_rdata, resp_err, er.rdata, er.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the handshake.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_before_issue: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  // Returns at the negedge before the op command transfers.
  task automatic wait_op(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cmd_stb && !cmd_busy && (cmd_word[33:32] != CMD_SETADDR)) begin
        ok = 1'b1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL op_wait: no op command within 64 cycles");
  endtask

  // Responder: answers `delay` cycles after the op transfer, optionally preceded
  // by an address echo that must be ignored. Leaves the DUT back in IDLE.
  task automatic respond(input int delay, input logic [33:0] w, input bit echo_first);
    bit ok;
    wait_op(ok);
    if (!ok) return;
    repeat (delay) @(posedge clk);
    #1;
    if (echo_first) begin
      rsp_stb  = 1'b1;
      rsp_word = {RSP_ADDR, 32'h0000_0FFF};
      tick();
      total++;
      if (resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL echo_dropped: got resp_valid=%b want 0", resp_valid);
      end
    end
    rsp_stb  = 1'b1;
    rsp_word = w;
    tick();
    rsp_stb  = 1'b0;
    total++;
    if (resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL resp_latency: got resp_valid=%b want 1", resp_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    total++;
    if ((cmd_stb !== 1'b0) || (cmd_word !== 34'h0) || (resp_valid !== 1'b0) ||
        (resp_rdata !== 32'h0) || (resp_err !== 1'b0) || (req_ready !== 1'b1)) begin
      bad++;
      $display("FAIL reset_values: got stb=%b word=%h rv=%b rd=%h err=%b rdy=%b want 0 0 0 0 0 1",
               cmd_stb, cmd_word, resp_valid, resp_rdata, resp_err, req_ready);
    end
  endtask

  task automatic test_read_miss();
    exp_cmd_q.push_back({CMD_SETADDR, 32'h0000_0100});
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    issue(1'b0, 32'h0000_0100, 32'h0);
    total++;
    if ((cmd_stb !== 1'b1) || (cmd_word !== {CMD_SETADDR, 32'h0000_0100})) begin
      bad++;
      $display("FAIL first_cmd_cycle1: got stb=%b word=%h want 1 %h",
               cmd_stb, cmd_word, {CMD_SETADDR, 32'h0000_0100});
    end
    respond(3, {RSP_RDATA, 32'hDEAD_BEEF}, 1'b0);
  endtask

  task automatic test_write_cache_hit();
    exp_cmd_q.push_back({CMD_WRITE, 32'h1234_5678});
    exp_resp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    issue(1'b1, 32'h0000_0104, 32'h1234_5678);
    total++;
    if ((cmd_stb !== 1'b1) || (cmd_word !== {CMD_WRITE, 32'h1234_5678})) begin
      bad++;
      $display("FAIL write_hit_cmd: got stb=%b word=%h want 1 %h",
               cmd_stb, cmd_word, {CMD_WRITE, 32'h1234_5678});
    end
    respond(2, {RSP_WACK, 32'hCAFE_0000}, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
    issue(1'b0, 32'h0000_0108, 32'h0);
    respond(1, {RSP_RDATA, 32'h0BAD_F00D}, 1'b1);
  endtask

  task automatic test_busy();
    exp_cmd_q.push_back({CMD_SETADDR, 32'h0000_0200});
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'hA5A5_0001, err: 1'b0});
    cmd_busy = 1'b1;
    issue(1'b0, 32'h0000_0200, 32'h0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ((cmd_stb !== 1'b1) || (cmd_word !== {CMD_SETADDR, 32'h0000_0200})) begin
        bad++;
        $display("FAIL busy_hold[%0d]: got stb=%b word=%h want 1 %h",
                 i, cmd_stb, cmd_word, {CMD_SETADDR, 32'h0000_0200});
      end
      tick();
    end
    cmd_busy = 1'b0;
    respond(1, {RSP_RDATA, 32'hA5A5_0001}, 1'b0);
  endtask

  task automatic test_timeout();
    bit ok;
    int first;
    exp_cmd_q.push_back({CMD_SETADDR, 32'h0000_0300});
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'hA5A5_0001, err: 1'b1});
    issue(1'b0, 32'h0000_0300, 32'h0);
    wait_op(ok);
    first = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (resp_valid === 1'b1) begin
        first = n;
        break;
      end
    end
    total++;
    if (first != TO_CYC + 1) begin
      bad++;
      $display("FAIL timeout_cycle: got resp_valid at edge %0d want %0d", first, TO_CYC + 1);
    end
    tick();
    // 0x204 was the cached next address before the timeout; it must be re-sent.
    exp_cmd_q.push_back({CMD_SETADDR, 32'h0000_0204});
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'h1111_2222, err: 1'b0});
    issue(1'b0, 32'h0000_0204, 32'h0);
    respond(2, {RSP_RDATA, 32'h1111_2222}, 1'b0);
  endtask

  task automatic test_misaligned();
    exp_resp_q.push_back('{rdata: 32'h1111_2222, err: 1'b1});
    issue(1'b0, 32'h0000_0102, 32'h0);
    total++;
    if ((resp_valid !== 1'b1) || (resp_err !== 1'b1) || (cmd_stb !== 1'b0)) begin
      bad++;
      $display("FAIL misaligned_cycle1: got rv=%b err=%b stb=%b want 1 1 0",
               resp_valid, resp_err, cmd_stb);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ((cmd_stb !== 1'b0) || (req_ready !== 1'b1)) begin
        bad++;
        $display("FAIL misaligned_quiet[%0d]: got stb=%b rdy=%b want 0 1", i, cmd_stb, req_ready);
      end
    end
  endtask

  task automatic test_wrap();
    exp_cmd_q.push_back({CMD_SETADDR, 32'hFFFF_FFFC});
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'h1357_9BDF, err: 1'b0});
    issue(1'b0, 32'hFFFF_FFFC, 32'h0);
    respond(1, {RSP_RDATA, 32'h1357_9BDF}, 1'b0);
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'h2468_ACE0, err: 1'b0});
    issue(1'b0, 32'h0000_0000, 32'h0);
    total++;
    if (cmd_word !== {CMD_READ, 32'h0}) begin
      bad++;
      $display("FAIL wrap_hit_cmd: got %h want %h", cmd_word, {CMD_READ, 32'h0});
    end
    respond(1, {RSP_RDATA, 32'h2468_ACE0}, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_cmd_q.push_back({CMD_SETADDR, 32'h0000_0500});
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'h5555_0000, err: 1'b0});
    issue(1'b0, 32'h0000_0500, 32'h0);
    respond(1, {RSP_RDATA, 32'h5555_0000}, 1'b0);
    // Cache hit, then reset while waiting for the response.
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    issue(1'b0, 32'h0000_0504, 32'h0);
    wait_op(ok);
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if ((cmd_stb !== 1'b0) || (resp_valid !== 1'b0) || (req_ready !== 1'b1) ||
        (resp_rdata !== 32'h0)) begin
      bad++;
      $display("FAIL reset_mid: got stb=%b rv=%b rdy=%b rd=%h want 0 0 1 0",
               cmd_stb, resp_valid, req_ready, resp_rdata);
    end
    tick();
    tick();
    reset    = 1'b0;
    rsp_stb  = 1'b1;
    rsp_word = {RSP_RDATA, 32'hDEAD_0000};
    tick();
    rsp_stb  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ((resp_valid !== 1'b0) || (req_ready !== 1'b1)) begin
        bad++;
        $display("FAIL late_rsp_ignored[%0d]: got rv=%b rdy=%b want 0 1", i, resp_valid, req_ready);
      end
      tick();
    end
    exp_cmd_q.push_back({CMD_SETADDR, 32'h0000_0504});
    exp_cmd_q.push_back({CMD_READ, 32'h0});
    exp_resp_q.push_back('{rdata: 32'h7777_8888, err: 1'b0});
    issue(1'b0, 32'h0000_0504, 32'h0);
    respond(1, {RSP_RDATA, 32'h7777_8888}, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    cmd_busy  = 1'b0;
    rsp_stb   = 1'b0;
    rsp_word  = '0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_read_miss();
    test_write_cache_hit();
    test_back_to_back();
    test_busy();
    test_timeout();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    tick();
    tick();
    total++;
    if ((exp_cmd_q.size() != 0) || (exp_resp_q.size() != 0)) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d cmds %0d resps left want 0 0",
               exp_cmd_q.size(), exp_resp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
